// File: rtl/core_types_pkg.sv
// Shared core types: ALU operation encodings, laid out as {funct3, funct7[5]}.
`timescale 1ns/10ps
package core_types_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'b0000,
        SUB  = 4'b0001,
        SLL  = 4'b0010,
        SLT  = 4'b0100,
        SLTU = 4'b0110,
        XOR  = 4'b1000,
        SRL  = 4'b1010,
        SRA  = 4'b1011,
        OR   = 4'b1100,
        AND  = 4'b1110
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// Integer ALU: combinational result and zero flag, plus a one-cycle registered copy
// of the result that loads only when the operands are flagged valid.
`timescale 1ns/10ps
module alu
    import core_types_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  alu_op_t           alu_op,
    input  logic [N_BITS-1:0] in0,
    input  logic [N_BITS-1:0] in1,
    input  logic              in_valid,
    output logic [N_BITS-1:0] out,
    output logic              zero,
    output logic [N_BITS-1:0] out_q,
    output logic              out_valid
);

    localparam int S = $clog2(N_BITS);

    logic        [S-1:0]      shamt_p0;
    logic signed [N_BITS-1:0] a_s_p0;
    logic signed [N_BITS-1:0] b_s_p0;
    logic        [N_BITS-1:0] res_p0;

    assign shamt_p0 = in1[S-1:0];
    assign a_s_p0   = $signed(in0);
    assign b_s_p0   = $signed(in1);

    // Stage p0: combinational datapath, independent of clk and rst_n
    always_comb begin
        res_p0 = '0;
        case (alu_op)
            ADD:     res_p0 = in0 + in1;
            SUB:     res_p0 = in0 - in1;
            SLL:     res_p0 = in0 << shamt_p0;
            SLT:     res_p0 = {{(N_BITS-1){1'b0}}, (a_s_p0 < b_s_p0)};
            SLTU:    res_p0 = {{(N_BITS-1){1'b0}}, (in0 < in1)};
            XOR:     res_p0 = in0 ^ in1;
            SRL:     res_p0 = in0 >> shamt_p0;
            SRA:     res_p0 = $unsigned(a_s_p0 >>> shamt_p0);
            OR:      res_p0 = in0 | in1;
            AND:     res_p0 = in0 & in1;
            default: res_p0 = '0;
        endcase
    end

    assign out  = res_p0;
    assign zero = (res_p0 == '0);

    // Stage p1: registered result; out_q holds when no valid operands arrive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= res_p0;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed and randomized check of the ALU against a plain-arithmetic reference model.
`timescale 1ns/10ps
module tb_alu;
    import core_types_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    alu_op_t     alu_op;
    logic [31:0] in0, in1;
    logic        in_valid;
    logic [31:0] out, out_q;
    logic        zero, out_valid;

    int vectors    = 0;
    int miscompares = 0;

    alu #(.N_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .in0(in0), .in1(in1),
        .in_valid(in_valid), .out(out), .zero(zero), .out_q(out_q), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned          sh;
        longint unsigned      ua, ub, p2;
        longint               sa, sb;
        logic [31:0]          r;
        sh = int'(b[4:0]);
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p2 = 64'd1 << sh;
        r  = 32'd0;
        case (op)
            4'b0000: r = 32'(ua + ub);
            4'b0001: r = 32'(ua - ub);
            4'b0010: r = 32'(ua * p2);
            4'b0100: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0110: r = (ua < ub) ? 32'd1 : 32'd0;
            4'b1000: r = a ^ b;
            4'b1010: r = 32'(ua / p2);
            4'b1011: for (int i = 0; i < 32; i++) r[i] = (i + int'(sh) < 32) ? a[i + int'(sh)] : a[31];
            4'b1100: r = a | b;
            4'b1110: r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_op = alu_op_t'(op);
        in0    = a;
        in1    = b;
        #0.1;
    endtask

    task automatic check_comb(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b);
        logic [31:0] e;
        apply(op, a, b);
        e = ref_alu(op, a, b);
        check({tag, "_out"}, out, e);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, (e == 32'd0)});
    endtask

    alu_op_t     legal_ops [10] = '{ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND};
    logic [31:0] exp_q;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic        rv;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        alu_op   = ADD;
        in0      = 32'd0;
        in1      = 32'd0;
        #1;
        check("reset_out_q", out_q, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_comb("comb_in_reset", 4'b0000, 32'd2, 32'd3);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner vectors
        check_comb("sub_neg", 4'b0001, 32'h0000_0005, 32'h0000_0007);
        check("sub_neg_const", out, 32'hFFFF_FFFE);
        check_comb("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
        check("add_wrap_zero", {31'd0, zero}, 32'd1);
        check_comb("sra_4", 4'b1011, 32'h8000_0000, 32'h0000_0024);
        check("sra_4_const", out, 32'hF800_0000);
        check_comb("srl_4", 4'b1010, 32'h8000_0000, 32'h0000_0024);
        check("srl_4_const", out, 32'h0800_0000);
        check_comb("sll_31", 4'b0010, 32'h0000_0001, 32'h0000_001F);
        check("sll_31_const", out, 32'h8000_0000);
        check_comb("slt_neg", 4'b0100, 32'hFFFF_FFFF, 32'h0000_0001);
        check("slt_neg_const", out, 32'd1);
        check_comb("sltu_big", 4'b0110, 32'hFFFF_FFFF, 32'h0000_0001);
        check("sltu_big_const", out, 32'd0);
        check_comb("sltu_eq0", 4'b0110, 32'd0, 32'd0);
        check("sltu_eq0_const", out, 32'd0);
        check_comb("sll_0", 4'b0010, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
        check_comb("srl_0", 4'b1010, 32'hDEAD_BEEF, 32'h0000_0020);
        check_comb("sra_0", 4'b1011, 32'hDEAD_BEEF, 32'h0000_0000);
        check("sra_0_const", out, 32'hDEAD_BEEF);
        check_comb("illegal_0011", 4'b0011, 32'h1234_5678, 32'h9ABC_DEF0);
        check("illegal_0011_const", out, 32'd0);
        check_comb("illegal_1111", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_comb("illegal_0101", 4'b0101, 32'h0000_0001, 32'h0000_0002);

        // Randomized stream with mid-cycle operand changes and registered tracking
        exp_q = out_q;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rop = 4'(legal_ops[$urandom_range(0, 9)]);
            if ($urandom_range(0, 19) == 0) rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            rv  = 1'($urandom_range(0, 1));
            in_valid = rv;
            check_comb("rand", rop, ra, rb);
            #($urandom_range(1, 3));
            ra = $urandom;
            check_comb("rand_mid", rop, ra, rb);
            if (rv) exp_q = ref_alu(rop, ra, rb);
            @(posedge clk);
            #1;
            check("rand_out_q", out_q, exp_q);
            check("rand_out_valid", {31'd0, out_valid}, {31'd0, rv});
        end

        // Hold: out_q keeps its value with in_valid low
        @(negedge clk);
        in_valid = 1'b0;
        check_comb("hold_comb", 4'b1100, 32'h0F0F_0000, 32'h0000_00FF);
        @(posedge clk);
        #1;
        check("hold_out_q", out_q, exp_q);
        check("hold_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream while valid operands are present
        @(negedge clk);
        in_valid = 1'b1;
        apply(4'b0000, 32'h1111_1111, 32'h2222_2222);
        @(posedge clk);
        #2;
        check("pre_rst_out_q", out_q, 32'h3333_3333);
        rst_n = 1'b0;
        #0.1;
        check("rst_async_out_q", out_q, 32'd0);
        check("rst_async_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_keeps_out", out, 32'h3333_3333);
        @(posedge clk);
        #1;
        check("rst_held_out_q", out_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1110, 32'hF0F0_F0F0, 32'hFF00_FF00);
        @(posedge clk);
        #1;
        check("post_rst_out_q", out_q, 32'hF000_F000);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have parameter N_BITS, default 32, giving the operand and result width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low, with ports clk and rst_n.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock for the registered result stage.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port alu_op, input, alu_op_t (4 bits): operation select.
REQ-006 The block SHALL have port in0, input, N_BITS: operand A (rs1).
REQ-007 The block SHALL have port in1, input, N_BITS: operand B (rs2 or immediate).
REQ-008 The block SHALL have port in_valid, input, 1 bit: operands and op are valid this cycle.
REQ-009 The block SHALL have port out, output, N_BITS: combinational result.
REQ-010 The block SHALL have port zero, output, 1 bit: combinational, equal to (out == 0).
REQ-011 The block SHALL have port out_q, output, N_BITS: registered copy of out.
REQ-012 The block SHALL have port out_valid, output, 1 bit: registered copy of in_valid.

Function
REQ-013 out SHALL be purely combinational from alu_op, in0 and in1, settling within the same delta/time step, with no dependence on clk or rst_n.
REQ-014 ADD (4'b0000) SHALL give in0 + in1, modulo 2^N_BITS, carry discarded.
REQ-015 SUB (4'b0001) SHALL give in0 - in1, modulo 2^N_BITS, borrow discarded.
REQ-016 SLL (4'b0010) SHALL give in0 << in1[S-1:0], where S = $clog2(N_BITS) (5 for 32 bits), and SHALL ignore the upper bits of in1.
REQ-017 SLT (4'b0100) SHALL give 1 if signed(in0) < signed(in1), else 0, zero-extended to N_BITS.
REQ-018 SLTU (4'b0110) SHALL give 1 if unsigned in0 < in1, else 0; equal operands, including both zero, SHALL give 0.
REQ-019 XOR (4'b1000) SHALL give in0 ^ in1.
REQ-020 SRL (4'b1010) SHALL give a logical right shift of in0 by in1[S-1:0], zero-filled.
REQ-021 SRA (4'b1011) SHALL give an arithmetic right shift of in0 by in1[S-1:0], filled with in0[N_BITS-1].
REQ-022 OR (4'b1100) SHALL give in0 | in1.
REQ-023 AND (4'b1110) SHALL give in0 & in1.
REQ-024 Any other alu_op encoding SHALL drive out to all zeros and SHALL NOT produce X.
REQ-025 A shift amount of 0 SHALL return in0 unchanged for SLL, SRL and SRA.
REQ-026 On each rising clk edge with in_valid=1, out_q SHALL load out; with in_valid=0, out_q SHALL hold its value.
REQ-027 out_valid SHALL load in_valid on every rising clk edge, giving one cycle of latency.

Reset
REQ-028 While rst_n=0, out_q SHALL be 0 and out_valid SHALL be 0, asynchronously and immediately on assertion.
REQ-029 Reset SHALL NOT affect out or zero.
REQ-030 The first clk edge after rst_n is released SHALL resume normal loading.

Structure
REQ-031 alu_op_t SHALL be a 4-bit enum in shared package core_types_pkg, with members ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR and AND using the encodings above.
REQ-032 The encoding SHALL equal {funct3, funct7[5]}, with funct7[5] forced to 0 for all operations except SUB and SRA.
REQ-033 The combinational datapath SHALL be a single case on alu_op; the registered stage SHALL be in the same module, with no sub-module.

Verification
REQ-034 SUB with in0=0x00000005, in1=0x00000007 -> out=0xFFFFFFFE, zero=0; ADD with in0=0xFFFFFFFF, in1=0x00000001 -> out=0x00000000, zero=1.
REQ-035 SRA with in0=0x80000000, in1=0x00000024 (amount 4) -> out=0xF8000000; SRL with the same inputs -> out=0x08000000; SLL with in0=0x00000001, in1=0x0000001F -> out=0x80000000.
REQ-036 SLT with in0=0xFFFFFFFF, in1=0x00000001 -> out=1; SLTU with the same inputs -> out=0; SLTU with in0=in1=0 -> out=0.
REQ-037 Randomized alu_op from the ten legal encodings, with in0 and in1 changed at random times -> out matches the reference model 0.1 time unit after any input change; an illegal op such as 4'b0011 -> out=0.
REQ-038 Reset is asserted mid-stream with in_valid=1 -> out_q=0 and out_valid=0 immediately; after release, in_valid=1 with AND 0xF0F0F0F0, 0xFF00FF00 -> out_q=0xF000F000 and out_valid=1 after one edge.
